// File: rtl/rr_lock_arbiter_if.sv
// rr_lock_arbiter_if: request/grant bundle between N requesting agents
// (master side) and the round-robin lock arbiter (slave side).
`timescale 1ns/1ps

interface rr_lock_arbiter_if #(
   parameter int N = 4
) ();
   localparam int IDW = $clog2(N);

   logic [N-1:0]   req;        // level request per agent
   logic [N-1:0]   done;       // release strobe per agent
   logic [N-1:0]   gnt;        // one-hot grant, zero when unowned
   logic           gnt_valid;  // |gnt
   logic [IDW-1:0] gnt_id;     // owner index, 0 when unowned
   logic           expired;    // owner was force-released by timeout

   modport master (
      output req,
      output done,
      input  gnt,
      input  gnt_valid,
      input  gnt_id,
      input  expired
   );

   modport slave (
      input  req,
      input  done,
      output gnt,
      output gnt_valid,
      output gnt_id,
      output expired
   );
endinterface

// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: N-way round-robin arbiter with grant locking.
// A winner owns the resource until it strobes done or drops its request;
// every hand-over passes through one GAP cycle and one IDLE decision edge,
// so gnt is low for two cycles between owners. Requests are registered once
// (req_q) before arbitration, giving a two-edge request-to-grant latency.
// Optional build macro RRLA_TIMEOUT_EN adds a forced release after MAXHOLD
// owned cycles, flagged by a one-cycle expired pulse.
`timescale 1ns/1ps

module rr_lock_arbiter #(
   parameter int N       = 4,   // requesters, 2..16
   parameter int MAXHOLD = 8    // owned cycles before forced release, 1..255
) (
   input  logic                  clock,
   input  logic                  reset_n,
   rr_lock_arbiter_if.slave      bus
);

   localparam int IDW = $clog2(N);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t         state;
   logic [N-1:0]   req_q;       // registered requests, the only arbitration input
   logic [IDW-1:0] ptr;         // highest-priority index for the next decision
   logic [7:0]     hold_cnt;    // cycles the current owner has held, saturating
   logic [N-1:0]   gnt_r;
   logic           gnt_valid_r;
   logic [IDW-1:0] gnt_id_r;

   // Round-robin decision
   logic           pick_found;
   logic [IDW-1:0] pick_id;
   logic [IDW-1:0] scan_idx;
   logic [IDW-1:0] next_ptr;
   logic [N-1:0]   pick_vec;

   // Owner status
   logic           owner_release;
   logic           timeout_hit;

   // Rotating priority scan over req_q starting at ptr; iterating from the
   // farthest slot back to ptr lets the closest set bit overwrite the others.
   always_comb begin
      // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
      pick_found = 1'b0;
      pick_id    = '0;
      scan_idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         scan_idx = IDW'((int'(ptr) + k) % N);
         if (req_q[scan_idx]) begin
            pick_found = 1'b1;
            pick_id    = scan_idx;
         end
      end
   end

   // Grant vector and pointer successor for the selected winner.
   always_comb begin
      pick_vec          = '0;
      pick_vec[pick_id] = 1'b1;
      next_ptr          = (pick_id == IDW'(N - 1)) ? '0 : pick_id + 1'b1;
   end

   // Release is honoured only from the current owner; foreign done is ignored.
   assign owner_release = bus.done[gnt_id_r] | ~req_q[gnt_id_r];

`ifdef RRLA_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAXHOLD - 1);
   logic expired_r;

   assign timeout_hit = (hold_cnt == HOLD_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   // Arbitration FSM with registered grant outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         req_q       <= '0;
         ptr         <= '0;
         hold_cnt    <= '0;
         gnt_r       <= '0;
         gnt_valid_r <= 1'b0;
         gnt_id_r    <= '0;
`ifdef RRLA_TIMEOUT_EN
         expired_r   <= 1'b0;
`endif
      end else begin
         // NOTE: state is updated with <= so every branch reads the pre-edge values.
         req_q <= bus.req;
`ifdef RRLA_TIMEOUT_EN
         expired_r <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (pick_found) begin
                  gnt_r       <= pick_vec;
                  gnt_valid_r <= 1'b1;
                  gnt_id_r    <= pick_id;
                  ptr         <= next_ptr;
                  hold_cnt    <= '0;
                  state       <= OWN;
               end
            end

            OWN: begin
               if (owner_release || timeout_hit) begin
                  gnt_r       <= '0;
                  gnt_valid_r <= 1'b0;
                  gnt_id_r    <= '0;
                  state       <= GAP;
`ifdef RRLA_TIMEOUT_EN
                  // A voluntary release on the limit edge is not an expiry.
                  expired_r   <= ~owner_release;
`endif
               end else if (hold_cnt != 8'hFF) begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end

            GAP: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt       = gnt_r;
   assign bus.gnt_valid = gnt_valid_r;
   assign bus.gnt_id    = gnt_id_r;
`ifdef RRLA_TIMEOUT_EN
   assign bus.expired   = expired_r;
`else
   assign bus.expired   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb_rr_lock_arbiter: vector table for rotation / foreign-done / request-drop,
// hand sequences for reset, hold/timeout and release-on-limit, then random
// traffic compared against an owner/cool-down reference model. Per-cycle
// invariants are checked on the falling edge throughout.
`timescale 1ns/1ps

module tb_rr_lock_arbiter;

   localparam int N       = 4;
   localparam int MAXHOLD = 8;
   localparam int NVEC    = 30;
   localparam int NRAND   = 2000;

   logic clock;
   logic reset_n;

   rr_lock_arbiter_if #(.N(N)) bus ();

   rr_lock_arbiter #(.N(N), .MAXHOLD(MAXHOLD)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      bus.req  = '0;
      bus.done = '0;
      reset_n  = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst.gnt", bus.gnt, 0);
      check("rst.valid", bus.gnt_valid, 0);
      check("rst.id", bus.gnt_id, 0);
      check("rst.expired", bus.expired, 0);
      reset_n = 1'b1;
   endtask

   // ---------------- per-cycle invariants ----------------
   logic [N-1:0] prev_gnt = '0;
   always @(negedge clock) begin
      check("inv.onehot", $onehot0(bus.gnt), 1);
      check("inv.valid", bus.gnt_valid, |bus.gnt);
      check("inv.id", (bus.gnt == '0) ? (bus.gnt_id == '0)
                                      : (bus.gnt == (N'(1) << bus.gnt_id)), 1);
      check("inv.no_switch", (prev_gnt == '0) || (bus.gnt == '0) || (bus.gnt == prev_gnt), 1);
      prev_gnt = bus.gnt;
   end

   // ---------------- reference model ----------------
   // Owner index (-1 = none), edges still to wait after a release before a
   // decision may happen, cycles owned so far, and the priority start index.
   int           m_owner;
   int           m_quiet;
   int           m_held;
   int           m_ptr;
   logic [N-1:0] m_req_q;
   bit           m_expired;

   function automatic void model_reset();
      m_owner   = -1;
      m_quiet   = 0;
      m_held    = 0;
      m_ptr     = 0;
      m_req_q   = '0;
      m_expired = 1'b0;
   endfunction

   // Advance the model across one rising edge given the inputs seen there.
   function automatic void model_edge(input logic [N-1:0] req_in, input logic [N-1:0] done_in);
      m_expired = 1'b0;
      if (m_owner >= 0) begin
         if (done_in[m_owner] || !m_req_q[m_owner]) begin
            m_owner = -1;
            m_quiet = 1;
         end
`ifdef RRLA_TIMEOUT_EN
         else if (m_held == MAXHOLD) begin
            m_owner   = -1;
            m_quiet   = 1;
            m_expired = 1'b1;
         end
`endif
         else begin
            m_held++;
         end
      end else if (m_quiet > 0) begin
         m_quiet--;
      end else begin
         for (int k = 0; k < N; k++) begin
            int c = (m_ptr + k) % N;
            if (m_req_q[c]) begin
               m_owner = c;
               m_ptr   = (c + 1) % N;
               m_held  = 1;
               break;
            end
         end
      end
      m_req_q = req_in;
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic [N-1:0] req;
      logic [N-1:0] done;
      logic [N-1:0] gnt;
      int           id;
   } vec_t;

   vec_t vec[NVEC];

   function automatic vec_t mk(input logic [N-1:0] r, input logic [N-1:0] d,
                               input logic [N-1:0] g, input int i);
      vec_t v;
      v.req  = r;
      v.done = d;
      v.gnt  = g;
      v.id   = i;
      return v;
   endfunction

   logic [N-1:0] rnd_req;
   logic [N-1:0] rnd_done;
   int           rnd_bit;

   initial begin
      // Rotation with owners releasing one cycle after grant, then a foreign
      // done while 2 owns, then a request drop and a skip from ptr=2 to 3.
      vec[0]  = mk(4'b1111, 4'b0000, 4'b0000, 0);
      vec[1]  = mk(4'b1111, 4'b0000, 4'b0001, 0);
      vec[2]  = mk(4'b1111, 4'b0001, 4'b0000, 0);
      vec[3]  = mk(4'b1111, 4'b0000, 4'b0000, 0);
      vec[4]  = mk(4'b1111, 4'b0000, 4'b0010, 1);
      vec[5]  = mk(4'b1111, 4'b0010, 4'b0000, 0);
      vec[6]  = mk(4'b1111, 4'b0000, 4'b0000, 0);
      vec[7]  = mk(4'b1111, 4'b0000, 4'b0100, 2);
      vec[8]  = mk(4'b1111, 4'b0001, 4'b0100, 2);
      vec[9]  = mk(4'b1111, 4'b0000, 4'b0100, 2);
      vec[10] = mk(4'b1111, 4'b0100, 4'b0000, 0);
      vec[11] = mk(4'b1111, 4'b0000, 4'b0000, 0);
      vec[12] = mk(4'b1111, 4'b0000, 4'b1000, 3);
      vec[13] = mk(4'b1111, 4'b1000, 4'b0000, 0);
      vec[14] = mk(4'b1111, 4'b0000, 4'b0000, 0);
      vec[15] = mk(4'b1111, 4'b0000, 4'b0001, 0);
      vec[16] = mk(4'b1111, 4'b0001, 4'b0000, 0);
      vec[17] = mk(4'b1111, 4'b0000, 4'b0000, 0);
      vec[18] = mk(4'b1111, 4'b0000, 4'b0010, 1);
      vec[19] = mk(4'b0000, 4'b0000, 4'b0010, 1);
      vec[20] = mk(4'b0000, 4'b0000, 4'b0000, 0);
      vec[21] = mk(4'b0000, 4'b0000, 4'b0000, 0);
      vec[22] = mk(4'b1001, 4'b0000, 4'b0000, 0);
      vec[23] = mk(4'b1001, 4'b0000, 4'b1000, 3);
      vec[24] = mk(4'b1001, 4'b1000, 4'b0000, 0);
      vec[25] = mk(4'b1001, 4'b0000, 4'b0000, 0);
      vec[26] = mk(4'b1001, 4'b0000, 4'b0001, 0);
      vec[27] = mk(4'b0000, 4'b0001, 4'b0000, 0);
      vec[28] = mk(4'b0000, 4'b0000, 4'b0000, 0);
      vec[29] = mk(4'b0000, 4'b0000, 4'b0000, 0);

      reset_n  = 1'b1;
      bus.req  = '0;
      bus.done = '0;
      #2;

      // ---- table run ----
      do_reset();
      for (int i = 0; i < NVEC; i++) begin
         bus.req  = vec[i].req;
         bus.done = vec[i].done;
         tick();
         check($sformatf("vec%0d.gnt", i), bus.gnt, vec[i].gnt);
         check($sformatf("vec%0d.id", i), bus.gnt_id, vec[i].id);
         check($sformatf("vec%0d.valid", i), bus.gnt_valid, |vec[i].gnt);
         check($sformatf("vec%0d.expired", i), bus.expired, 0);
      end

      // ---- reset during ownership ----
      do_reset();
      bus.req = 4'b0100;
      tick();
      check("rmid.latch_gnt", bus.gnt, 4'b0000);
      tick();
      check("rmid.grant_gnt", bus.gnt, 4'b0100);
      check("rmid.grant_id", bus.gnt_id, 2);
      #2;
      reset_n = 1'b0;
      #1;
      check("rmid.async_gnt", bus.gnt, 4'b0000);
      check("rmid.async_valid", bus.gnt_valid, 0);
      check("rmid.async_id", bus.gnt_id, 0);
      bus.req = 4'b0011;
      repeat (2) @(posedge clock);
      #1;
      check("rmid.held_gnt", bus.gnt, 4'b0000);
      reset_n = 1'b1;
      tick();
      check("rmid.relatch_gnt", bus.gnt, 4'b0000);
      tick();
      check("rmid.first_gnt", bus.gnt, 4'b0001);
      check("rmid.first_id", bus.gnt_id, 0);

      // ---- long hold: timeout or unbounded ownership ----
      do_reset();
      bus.req = 4'b0010;
      tick();
      check("hold.latch_gnt", bus.gnt, 4'b0000);
      tick();
      check("hold.c1_gnt", bus.gnt, 4'b0010);
`ifdef RRLA_TIMEOUT_EN
      for (int i = 2; i <= MAXHOLD; i++) begin
         tick();
         check($sformatf("hold.c%0d_gnt", i), bus.gnt, 4'b0010);
         check($sformatf("hold.c%0d_expired", i), bus.expired, 0);
      end
      tick();
      check("hold.tmo_gnt", bus.gnt, 4'b0000);
      check("hold.tmo_expired", bus.expired, 1);
      tick();
      check("hold.idle_gnt", bus.gnt, 4'b0000);
      check("hold.idle_expired", bus.expired, 0);
      tick();
      check("hold.regrant_gnt", bus.gnt, 4'b0010);
      check("hold.regrant_expired", bus.expired, 0);
`else
      for (int i = 2; i <= 20; i++) begin
         tick();
         check($sformatf("hold.c%0d_gnt", i), bus.gnt, 4'b0010);
         check($sformatf("hold.c%0d_expired", i), bus.expired, 0);
      end
`endif

      // ---- done on the limit edge: single release, no expiry ----
      do_reset();
      bus.req = 4'b0011;
      tick();
      tick();
      check("lim.grant_gnt", bus.gnt, 4'b0001);
      for (int i = 2; i <= MAXHOLD; i++) begin
         tick();
         check($sformatf("lim.c%0d_gnt", i), bus.gnt, 4'b0001);
      end
      bus.done = 4'b0001;
      tick();
      bus.done = 4'b0000;
      check("lim.rel_gnt", bus.gnt, 4'b0000);
      check("lim.rel_expired", bus.expired, 0);
      tick();
      check("lim.gap_gnt", bus.gnt, 4'b0000);
      check("lim.gap_expired", bus.expired, 0);
      tick();
      check("lim.next_gnt", bus.gnt, 4'b0010);
      check("lim.next_id", bus.gnt_id, 1);

      // ---- random traffic against the model ----
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < NRAND; cyc++) begin
         rnd_req = bus.req;
         if ($urandom_range(0, 3) == 0) begin
            rnd_bit          = int'($urandom_range(0, N - 1));
            rnd_req[rnd_bit] = ~rnd_req[rnd_bit];
         end
         if ($urandom_range(0, 63) == 0) rnd_req = '1;
         rnd_done = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
         bus.req  = rnd_req;
         bus.done = rnd_done;
         model_edge(rnd_req, rnd_done);
         tick();
         check($sformatf("rnd%0d.gnt", cyc), bus.gnt,
               (m_owner >= 0) ? (N'(1) << m_owner) : N'(0));
         check($sformatf("rnd%0d.id", cyc), bus.gnt_id, (m_owner >= 0) ? m_owner : 0);
         check($sformatf("rnd%0d.valid", cyc), bus.gnt_valid, (m_owner >= 0) ? 1 : 0);
         check($sformatf("rnd%0d.expired", cyc), bus.expired, m_expired);
      end

      bus.req  = '0;
      bus.done = '0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog expired");
   end

endmodule
